uart_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 37 +++
 rtl/uart_sync.sv | 27 ++
 rtl/uart_rx.sv | 148 ++++++++++++++
 tb/tb_uart_rx.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants: parity/stop encodings (common with the transmitter) and RX state codes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

    // Parity modes
    localparam int PAR_NONE  = 0;
    localparam int PAR_EVEN  = 1;
    localparam int PAR_ODD   = 2;
    localparam int PAR_MARK  = 3;
    localparam int PAR_SPACE = 4;

    // Stop-bit modes
    localparam int STOP_1 = 0;
    localparam int STOP_2 = 1;

    // Receiver FSM states
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_HOLD   = 3'd5;

    // Expected parity bit given the mode and the XOR reduction of the data word
    function automatic logic par_expect(input int mode, input logic data_xor);
        logic r;
        case (mode)
            PAR_EVEN:  r = data_xor;
            PAR_ODD:   r = ~data_xor;
            PAR_MARK:  r = 1'b1;
            default:   r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for an asynchronous, idle-high input.
// Latency: 2 clk cycles from input change to o_q.
// Backpressure: none; samples every cycle.
module uart_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_s1;
    logic r_s2;

    // Resync chain; resets to the idle (high) level so no false start follows reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
        end
    end

    assign o_q = r_s2;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start, N data bits MSB first, optional parity, 1 or 2 stop bits, OVS clks per bit.
// Latency: valid pulses on the edge of the last stop-bit sample (mid stop bit + 2 sync cycles).
// Backpressure: none; data is held until the next valid, consumer must keep up with one frame time.
module uart_rx
    import uart_pkg::*;
#(
    parameter int N      = 8,
    parameter int PARITY = PAR_NONE,
    parameter int STOP   = STOP_1,
    parameter int OVS    = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         d,
    output logic [N-1:0] data,
    output logic         valid,
    output logic         perr,
    output logic         ferr,
    output logic         busy
);

    localparam int TW = $clog2(OVS);
    localparam int BW = $clog2(N + 1);

    logic          w_rx_s;
    logic          w_half;
    logic          w_full;
    logic          w_ferr_nxt;
    logic          w_par_exp;

    logic [2:0]    r_state;
    logic [TW-1:0] r_tick;
    logic [BW-1:0] r_bit;
    logic [N-1:0]  r_sh;
    logic          r_perr_n;
    logic          r_ferr_n;
    logic [N-1:0]  r_data;
    logic          r_valid;
    logic          r_perr;
    logic          r_ferr;

    uart_sync u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (d),
        .o_q (w_rx_s)
    );

    // Sample points: mid start bit, then every full bit period
    assign w_half     = (r_tick == TW'(OVS / 2 - 1));
    assign w_full     = (r_tick == TW'(OVS - 1));
    assign w_ferr_nxt = r_ferr_n | ~w_rx_s;
    assign w_par_exp  = par_expect(PARITY, ^r_sh);

    // Frame FSM with tick/bit counters, shift register and registered result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_tick   <= '0;
            r_bit    <= '0;
            r_sh     <= '0;
            r_perr_n <= 1'b0;
            r_ferr_n <= 1'b0;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_perr   <= 1'b0;
            r_ferr   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_tick  <= r_tick + TW'(1);
            case (r_state)
                S_IDLE: begin
                    r_tick <= '0;
                    r_bit  <= '0;
                    if (!w_rx_s) begin
                        r_state  <= S_START;
                        r_perr_n <= 1'b0;
                        r_ferr_n <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_half) begin
                        r_tick  <= '0;
                        r_bit   <= '0;
                        // A line back high at mid start bit was a glitch
                        r_state <= w_rx_s ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_full) begin
                        r_tick <= '0;
                        r_sh   <= {r_sh[N-2:0], w_rx_s};
                        if (r_bit == BW'(N - 1)) begin
                            r_bit   <= '0;
                            r_state <= (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
                        end else begin
                            r_bit <= r_bit + BW'(1);
                        end
                    end
                end
                S_PARITY: begin
                    if (w_full) begin
                        r_tick   <= '0;
                        r_bit    <= '0;
                        r_perr_n <= (w_rx_s != w_par_exp);
                        r_state  <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (w_full) begin
                        r_tick   <= '0;
                        r_ferr_n <= w_ferr_nxt;
                        if (r_bit == BW'(STOP)) begin
                            r_bit   <= '0;
                            r_data  <= r_sh;
                            r_perr  <= r_perr_n;
                            r_ferr  <= w_ferr_nxt;
                            r_valid <= 1'b1;
                            // After a framing error wait for the line to go idle before rearming
                            r_state <= w_ferr_nxt ? S_HOLD : S_IDLE;
                        end else begin
                            r_bit <= r_bit + BW'(1);
                        end
                    end
                end
                S_HOLD: begin
                    r_tick <= '0;
                    r_bit  <= '0;
                    if (w_rx_s) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_tick  <= '0;
                    r_bit   <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign data  = r_data;
    assign valid = r_valid;
    assign perr  = r_perr;
    assign ferr  = r_ferr;
    assign busy  = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: dut1 (8E1) and dut2 (8N2), directed frames with hand-computed results.
// Latency: checks valid results whenever they appear; stimulus pushes expectations ahead of each frame.
// Backpressure: n/a.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int OVS = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       d1, d2;
    logic [7:0] data1, data2;
    logic       valid1, perr1, ferr1, busy1;
    logic       valid2, perr2, ferr2, busy2;

    int checks = 0;
    int errors = 0;

    // {data, perr, ferr}
    logic [9:0] q1[$];
    logic [9:0] q2[$];
    logic       pv1 = 1'b0;
    logic       pv2 = 1'b0;

    always #5 clk = ~clk;

    uart_rx #(.N(8), .PARITY(PAR_EVEN), .STOP(STOP_1), .OVS(OVS)) dut1 (
        .clk(clk), .rst(rst), .d(d1), .data(data1), .valid(valid1),
        .perr(perr1), .ferr(ferr1), .busy(busy1)
    );

    uart_rx #(.N(8), .PARITY(PAR_NONE), .STOP(STOP_2), .OVS(OVS)) dut2 (
        .clk(clk), .rst(rst), .d(d2), .data(data2), .valid(valid2),
        .perr(perr2), .ferr(ferr2), .busy(busy2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor for dut1: pop and compare on every valid
    always @(negedge clk) begin
        logic [9:0] e;
        if (valid1) begin
            if (pv1) begin
                checks++;
                errors++;
                $display("FAIL dut1 valid high two cycles");
            end
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut1 unexpected valid: data %0h perr %0b ferr %0b", data1, perr1, ferr1);
            end else begin
                e = q1.pop_front();
                check("dut1 data", 32'(data1), 32'(e[9:2]));
                check("dut1 perr", 32'(perr1), 32'(e[1]));
                check("dut1 ferr", 32'(ferr1), 32'(e[0]));
                check("dut1 busy at valid", 32'(busy1), 32'(e[0]));
            end
        end
        pv1 = valid1;
    end

    // Monitor for dut2
    always @(negedge clk) begin
        logic [9:0] e;
        if (valid2) begin
            if (pv2) begin
                checks++;
                errors++;
                $display("FAIL dut2 valid high two cycles");
            end
            if (q2.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut2 unexpected valid: data %0h perr %0b ferr %0b", data2, perr2, ferr2);
            end else begin
                e = q2.pop_front();
                check("dut2 data", 32'(data2), 32'(e[9:2]));
                check("dut2 perr", 32'(perr2), 32'(e[1]));
                check("dut2 ferr", 32'(ferr2), 32'(e[0]));
                check("dut2 busy at valid", 32'(busy2), 32'(e[0]));
            end
        end
        pv2 = valid2;
    end

    task automatic drive_bit(input int which, input logic b, input int cycles);
        if (which == 0) d1 = b;
        else            d2 = b;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic send_frame(input int which, input logic [7:0] v, input bit has_par,
                              input logic par_bit, input logic [1:0] stops, input int nstop);
        drive_bit(which, 1'b0, OVS);
        for (int i = 7; i >= 0; i--) drive_bit(which, v[i], OVS);
        if (has_par) drive_bit(which, par_bit, OVS);
        for (int s = 0; s < nstop; s++) drive_bit(which, stops[s], OVS);
    endtask

    initial begin
        rst = 1'b1;
        d1  = 1'b1;
        d2  = 1'b1;
        repeat (3) @(negedge clk);
        check("reset data1", 32'(data1), 32'h0);
        check("reset valid1", 32'(valid1), 32'h0);
        check("reset perr1", 32'(perr1), 32'h0);
        check("reset ferr1", 32'(ferr1), 32'h0);
        check("reset busy1", 32'(busy1), 32'h0);
        check("reset busy2", 32'(busy2), 32'h0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // 1: 0xA5 with correct even parity (four ones -> 0)
        q1.push_back({8'hA5, 1'b0, 1'b0});
        send_frame(0, 8'hA5, 1'b1, 1'b0, 2'b11, 1);
        d1 = 1'b1;
        repeat (2 * OVS) @(negedge clk);
        check("t1 frame consumed", 32'(q1.size()), 32'h0);
        check("t1 busy idle", 32'(busy1), 32'h0);

        // 2: 0xA5 with wrong parity bit
        q1.push_back({8'hA5, 1'b1, 1'b0});
        send_frame(0, 8'hA5, 1'b1, 1'b1, 2'b11, 1);
        d1 = 1'b1;
        repeat (2 * OVS) @(negedge clk);
        check("t2 frame consumed", 32'(q1.size()), 32'h0);

        // 3: 0x3C, stop bit low, line held low (break)
        q1.push_back({8'h3C, 1'b0, 1'b1});
        send_frame(0, 8'h3C, 1'b1, 1'b0, 2'b00, 1);
        repeat (40 * OVS) @(negedge clk);
        check("t3 frame consumed", 32'(q1.size()), 32'h0);
        check("t3 busy in hold", 32'(busy1), 32'h1);
        d1 = 1'b1;
        repeat (4) @(negedge clk);
        check("t3 busy released", 32'(busy1), 32'h0);
        repeat (2 * OVS) @(negedge clk);

        // 4: three-cycle low glitch on the idle line
        d1 = 1'b0;
        repeat (3) @(negedge clk);
        check("t4 glitch seen", 32'(busy1), 32'h1);
        d1 = 1'b1;
        repeat (OVS / 2 + 2) @(negedge clk);
        check("t4 back to idle", 32'(busy1), 32'h0);
        check("t4 data held", 32'(data1), 32'h3C);
        check("t4 ferr held", 32'(ferr1), 32'h1);
        repeat (2 * OVS) @(negedge clk);

        // 5: two stop bits, 0x00 then 0xFF with no idle gap
        q2.push_back({8'h00, 1'b0, 1'b0});
        q2.push_back({8'hFF, 1'b0, 1'b0});
        send_frame(1, 8'h00, 1'b0, 1'b0, 2'b11, 2);
        send_frame(1, 8'hFF, 1'b0, 1'b0, 2'b11, 2);
        d2 = 1'b1;
        repeat (2 * OVS) @(negedge clk);
        check("t5 frames consumed", 32'(q2.size()), 32'h0);
        check("t5 busy idle", 32'(busy2), 32'h0);

        // 6: reset during the 4th data bit of 0x5A, then a clean 0x81
        drive_bit(0, 1'b0, OVS);
        drive_bit(0, 1'b0, OVS);
        drive_bit(0, 1'b1, OVS);
        drive_bit(0, 1'b0, OVS);
        drive_bit(0, 1'b1, OVS / 2);
        check("t6 busy before reset", 32'(busy1), 32'h1);
        rst = 1'b1;
        d1  = 1'b1;
        @(negedge clk);
        check("t6 reset data", 32'(data1), 32'h0);
        check("t6 reset valid", 32'(valid1), 32'h0);
        check("t6 reset perr", 32'(perr1), 32'h0);
        check("t6 reset ferr", 32'(ferr1), 32'h0);
        check("t6 reset busy", 32'(busy1), 32'h0);
        rst = 1'b0;
        repeat (3 * OVS) @(negedge clk);
        check("t6 idle after reset", 32'(busy1), 32'h0);
        q1.push_back({8'h81, 1'b0, 1'b0});
        send_frame(0, 8'h81, 1'b1, 1'b0, 2'b11, 1);
        d1 = 1'b1;
        repeat (2 * OVS) @(negedge clk);
        check("t6 frame consumed", 32'(q1.size()), 32'h0);

        repeat (4 * OVS) @(negedge clk);
        check("final q1 empty", 32'(q1.size()), 32'h0);
        check("final q2 empty", 32'(q2.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
